// File: rtl/tab_arquivos_param.sv
// Parametrised file table: synchronous write, registered read with valid strobe,
// hardware clear sweep after reset/request. Optional macro TABARQ_BYPASS_EN selects write-first forwarding.
module tab_arquivos_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 201,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;
    localparam logic [CMP_W-1:0] DEPTH_A  = CMP_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

`ifdef TABARQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                busy_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_ok_c;
    logic                rd_ok_c;
    logic [PTR_W-1:0]    wr_idx_c;
    logic [PTR_W-1:0]    rd_idx_c;
    logic                mem_we_c;
    logic [PTR_W-1:0]    mem_idx_c;
    logic [DATA_W-1:0]   mem_wdata_c;
    logic [DATA_W-1:0]   rd_word_c;

    // Address decode and array write-port steering (sweep owns the port in CLEAR)
    always_comb begin
        wr_ok_c     = ({1'b0, wr_addr} < DEPTH_A);
        rd_ok_c     = ({1'b0, rd_addr} < DEPTH_A);
        wr_idx_c    = PTR_W'(wr_addr);
        rd_idx_c    = PTR_W'(rd_addr);
        ptr_d       = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        mem_we_c    = 1'b0;
        mem_idx_c   = wr_idx_c;
        mem_wdata_c = wr_data;
        if (state_q == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_idx_c   = ptr_q;
            mem_wdata_c = '0;
        end else if (wr_en && wr_ok_c) begin
            mem_we_c = 1'b1;
        end
        rd_word_c = '0;
        if (rd_ok_c) begin
            if (BYPASS && wr_en && wr_ok_c && (wr_addr == rd_addr)) begin
                rd_word_c = wr_data;
            end else begin
                rd_word_c = mem_q[rd_idx_c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem_q[mem_idx_c] <= mem_wdata_c;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    ptr_q <= ptr_d;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (rd_en) begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= rd_word_c;
                    end
                    err_q <= (wr_en && !wr_ok_c) || (rd_en && !rd_ok_c);
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
